enum_stream_buffer: RTL and testbench
=====================================

# enum_stream_buffer

Downstream consumer of the `pkg::alias_t` code stream.
- Accepts 8-bit enum codes over a valid/ready handshake and discards codes outside the enumeration (`ONE`=0, `TWO`=1, `THREE`=2).
- Buffers legal codes in a small FIFO and presents them as `pkg::struct_t` words to the next stage.
- Keeps saturating per-code occurrence counters and a sticky illegal-code monitor for status readback.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `CNT_W`, 16, width of each occurrence counter.
- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  1  upstream code valid.
- `in_ready`  output  1  block can accept a code this cycle.
- `in_data`  input  8  code, type `pkg::alias_t`.
- `out_valid`  output  1  head entry available.
- `out_ready`  input  1  downstream accepts head.
- `out_data`  output  8  head entry, type `pkg::struct_t` (field `x` = code).
- `level`  output  $clog2(DEPTH+1)  current occupancy.
- `cnt_one`, `cnt_two`, `cnt_three`  output  CNT_W each  accepted legal codes per value.
- `illegal_seen`  output  1  sticky; set when an illegal code is accepted.
- `illegal_code`  output  8  first illegal code captured since reset or clear.
- `clr_counts`  input  1  synchronous clear of counters and illegal monitor.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- Accept condition:
  - An input is accepted when `in_valid && in_ready`.
  - `in_ready = (level != DEPTH)`. `in_ready` is not raised by a same-cycle pop.
- Legality:
  - An accepted code is legal when `in_data <= 8'd2`.
  - Legal accept: write the code to the tail, advance the write pointer, increment the matching counter.
  - Illegal accept: nothing is written, no counter changes, `illegal_seen` is set.
  - `illegal_code` loads only if `illegal_seen` was 0 before this cycle.
  - Illegal codes are always consumed, i.e. the upstream is never stalled by them.
- Output side:
  - `out_valid = (level != 0)`.
  - `out_data.x` = head entry.
  - A pop occurs when `out_valid && out_ready`; the read pointer advances.
- Pointers:
  - `$clog2(DEPTH)` bits each; wrap modulo `DEPTH`.
  - Occupancy is tracked by the `level` register, not by pointer comparison.
- Simultaneous legal push and pop:
  - `level` is unchanged and both pointers advance.
  - Allowed at any level < DEPTH, including level 1 (the head is popped while the new entry lands behind it).
- Counters saturate at all-ones and hold there.
- `clr_counts` priority:
  - `clr_counts` = 1 zeroes all three counters, `illegal_seen` and `illegal_code` next edge.
  - Clear beats a same-cycle increment or illegal capture; that event is lost.
  - FIFO contents and handshakes are unaffected by the clear.
- Reset mid-operation discards all FIFO contents immediately; no handshake completes in the reset cycle.

## Timing
- Reset values:
  - `level` = 0, `out_valid` = 0, `in_ready` = 1.
  - `out_data` = 0 (storage is reset to 0).
  - All counters 0, `illegal_seen` 0, `illegal_code` 0.
- Latency: a legal code accepted at edge N is visible on `out_valid` / `out_data` after edge N (one cycle). There is no combinational in→out path.
- `in_ready`, `out_valid` and `level` are functions of registered state only.
- Counter and illegal-status updates are visible one cycle after the accepting edge.
- Sustained throughput: one code per cycle when `out_ready` is held at 1.

## Test plan
- Reset, then push `ONE`, `TWO`, `THREE` on consecutive cycles with `out_ready=0`:
  - `level` reads 3.
  - `out_data` = 0x00, 0x01, 0x02 in order once `out_ready=1`.
  - Counters end at 1/1/1.
- Push 5 legal codes with `out_ready=0`, `DEPTH=4`:
  - `in_ready` drops after the 4th accept; the 5th is held with `in_valid` until a pop.
  - Then it is accepted with no loss or duplication.
- Stream 0x07 then 0xFF:
  - `illegal_seen`=1, `illegal_code`=0x07 (not 0xFF).
  - `level` stays 0 and counters stay 0.
- Continuous stream of 20 codes with `out_ready=1`:
  - One output per cycle after a single-cycle initial latency.
  - `level` never exceeds 1; pointers wrap correctly past index 3.
- Force `cnt_one` to all-ones minus 1, push `ONE` twice: the counter reaches all-ones and holds.
- Assert `clr_counts` coincident with a legal `TWO` accept: `cnt_two`=0 next cycle and the `TWO` still appears on `out_data`. Then drop `rst_n` while `level`=2: `level`=0 and `out_valid`=0 immediately.

Source files
------------

// File: rtl/enum_stream_buffer_if.sv
// rtl/enum_stream_buffer_if.sv - code/word types and the in/out stream handshake bundle
// The producer side drives codes in and takes words out; the buffer sits on the slave modport.
package pkg;
  typedef enum logic [7:0] {
    ONE   = 8'd0,
    TWO   = 8'd1,
    THREE = 8'd2
  } alias_t;

  typedef struct packed {
    alias_t x;
  } struct_t;
endpackage

interface enum_stream_buffer_if;
  logic        in_valid;
  logic        in_ready;
  pkg::alias_t in_data;
  logic        out_valid;
  logic        out_ready;
  pkg::struct_t out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/enum_stream_buffer.sv
// rtl/enum_stream_buffer.sv - filters enum codes into a small FIFO with occurrence counters
// Illegal codes are swallowed at the input and only recorded by the sticky monitor.
module enum_stream_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  enum_stream_buffer_if.slave        bus,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNT_W-1:0]           cnt_one,
  output logic [CNT_W-1:0]           cnt_two,
  output logic [CNT_W-1:0]           cnt_three,
  output logic                       illegal_seen,
  output logic [7:0]                 illegal_code,
  input  logic                       clr_counts
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  pkg::struct_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            accept;
  logic            legal;
  logic            push;
  logic            pop;

  // Handshake flags come from the level register only, so no input reaches an output.
  assign bus.in_ready  = (level != LW'(DEPTH));
  assign bus.out_valid = (level != '0);
  assign bus.out_data  = mem[rd_ptr];

  assign accept = bus.in_valid && bus.in_ready;
  assign legal  = (bus.in_data <= 8'd2);
  assign push   = accept && legal;
  assign pop    = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr].x <= bus.in_data;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        level <= level + LW'(1);
      end else if (pop && !push) begin
        level <= level - LW'(1);
      end
    end
  end

  // A clear in the same cycle as an accept wins; that accept is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_one   <= '0;
      cnt_two   <= '0;
      cnt_three <= '0;
    end else if (clr_counts) begin
      cnt_one   <= '0;
      cnt_two   <= '0;
      cnt_three <= '0;
    end else if (push) begin
      case (bus.in_data)
        pkg::ONE: begin
          if (cnt_one != '1) cnt_one <= cnt_one + CNT_W'(1);
        end
        pkg::TWO: begin
          if (cnt_two != '1) cnt_two <= cnt_two + CNT_W'(1);
        end
        default: begin
          if (cnt_three != '1) cnt_three <= cnt_three + CNT_W'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_seen <= 1'b0;
      illegal_code <= 8'h00;
    end else if (clr_counts) begin
      illegal_seen <= 1'b0;
      illegal_code <= 8'h00;
    end else if (accept && !legal) begin
      illegal_seen <= 1'b1;
      if (!illegal_seen) illegal_code <= bus.in_data;
    end
  end
endmodule

// File: tb/tb_enum_stream_buffer.sv
// tb/tb_enum_stream_buffer.sv - directed self-checking bench for enum_stream_buffer
// A second narrow-counter instance exercises saturation without long count-up runs.
module tb_enum_stream_buffer;
  logic clk;
  logic rst_n;
  logic clr_counts;
  logic clr2;
  logic [2:0]  level;
  logic [15:0] cnt_one, cnt_two, cnt_three;
  logic        illegal_seen;
  logic [7:0]  illegal_code;
  logic [2:0]  level2;
  logic [1:0]  c2_one, c2_two, c2_three;
  logic        ill2_seen;
  logic [7:0]  ill2_code;

  int tests;
  int errors;

  enum_stream_buffer_if bus ();
  enum_stream_buffer_if bus2 ();

  enum_stream_buffer #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .level(level),
    .cnt_one(cnt_one), .cnt_two(cnt_two), .cnt_three(cnt_three),
    .illegal_seen(illegal_seen), .illegal_code(illegal_code), .clr_counts(clr_counts)
  );

  enum_stream_buffer #(.DEPTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .level(level2),
    .cnt_one(c2_one), .cnt_two(c2_two), .cnt_three(c2_three),
    .illegal_seen(ill2_seen), .illegal_code(ill2_code), .clr_counts(clr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_q [4];
    tests = 0;
    errors = 0;
    rst_n = 1'b0;
    clr_counts = 1'b0;
    clr2 = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = pkg::ONE;
    bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0;
    bus2.in_data = pkg::ONE;
    bus2.out_ready = 1'b1;
    step();
    step();
    check("rst_level", 32'(level), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_cnts", {cnt_one, cnt_two | cnt_three}, 0);
    check("rst_illegal", {23'd0, illegal_seen, illegal_code}, 0);
    rst_n = 1'b1;
    step();

    // ONE, TWO, THREE with the output stalled
    bus.in_valid = 1'b1;
    bus.in_data = pkg::ONE;
    step();
    check("lat_out_valid", 32'(bus.out_valid), 1);
    check("lat_out_data", 32'(bus.out_data), 8'h00);
    bus.in_data = pkg::TWO;
    step();
    bus.in_data = pkg::THREE;
    step();
    bus.in_valid = 1'b0;
    check("three_level", 32'(level), 3);
    check("three_cnt_one", 32'(cnt_one), 1);
    check("three_cnt_two", 32'(cnt_two), 1);
    check("three_cnt_three", 32'(cnt_three), 1);
    bus.out_ready = 1'b1;
    check("three_head0", 32'(bus.out_data), 8'h00);
    step();
    check("three_head1", 32'(bus.out_data), 8'h01);
    step();
    check("three_head2", 32'(bus.out_data), 8'h02);
    step();
    check("three_empty", {30'd0, bus.out_valid, level == 3'd0}, 1);
    bus.out_ready = 1'b0;

    // fill to DEPTH and hold a fifth code until space opens
    exp_q = '{8'h00, 8'h01, 8'h02, 8'h00};
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = pkg::alias_t'(exp_q[i]);
      step();
    end
    check("full_in_ready", 32'(bus.in_ready), 0);
    check("full_level", 32'(level), 4);
    bus.in_data = pkg::TWO;
    step();
    check("full_hold_level", 32'(level), 4);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("full_pop_level", 32'(level), 3);
    check("full_pop_ready", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    check("full_fifth_level", 32'(level), 4);
    exp_q = '{8'h01, 8'h02, 8'h00, 8'h01};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d", i), 32'(bus.out_data), 32'(exp_q[i]));
      step();
    end
    bus.out_ready = 1'b0;
    check("drain_level", 32'(level), 0);
    check("fill_cnt_one", 32'(cnt_one), 3);
    check("fill_cnt_two", 32'(cnt_two), 3);
    check("fill_cnt_three", 32'(cnt_three), 2);

    clr_counts = 1'b1;
    step();
    clr_counts = 1'b0;
    check("clr_cnts", {cnt_one, cnt_two | cnt_three}, 0);

    // illegal codes: first one captured, nothing buffered
    bus.in_valid = 1'b1;
    bus.in_data = pkg::alias_t'(8'h07);
    step();
    check("ill_in_ready", 32'(bus.in_ready), 1);
    bus.in_data = pkg::alias_t'(8'hFF);
    step();
    bus.in_valid = 1'b0;
    check("ill_seen", 32'(illegal_seen), 1);
    check("ill_code", 32'(illegal_code), 8'h07);
    check("ill_level", 32'(level), 0);
    check("ill_cnts", {cnt_one, cnt_two | cnt_three}, 0);

    // back-to-back stream with the output always ready
    bus.out_ready = 1'b1;
    check("str_pre_valid", 32'(bus.out_valid), 0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_data = pkg::alias_t'(8'(i % 3));
      step();
      check($sformatf("str_data%0d", i), {23'd0, bus.out_valid, bus.out_data}, {24'd1, 8'(i % 3)});
      check($sformatf("str_level%0d", i), 32'(level), 1);
    end
    bus.in_valid = 1'b0;
    step();
    check("str_end_level", 32'(level), 0);
    check("str_cnt_one", 32'(cnt_one), 7);
    check("str_cnt_three", 32'(cnt_three), 6);
    bus.out_ready = 1'b0;

    // saturation on the 2-bit counter instance
    bus2.in_valid = 1'b1;
    bus2.in_data = pkg::ONE;
    step();
    step();
    check("sat_pre", 32'(c2_one), 2);
    step();
    check("sat_reach", 32'(c2_one), 3);
    step();
    bus2.in_valid = 1'b0;
    check("sat_hold", 32'(c2_one), 3);

    // clear coincident with a legal TWO accept
    bus.in_valid = 1'b1;
    bus.in_data = pkg::TWO;
    clr_counts = 1'b1;
    step();
    clr_counts = 1'b0;
    check("clr_cnt_two", 32'(cnt_two), 0);
    check("clr_ill_seen", 32'(illegal_seen), 0);
    check("clr_fifo_data", {23'd0, bus.out_valid, bus.out_data}, {24'd1, 8'h01});
    bus.in_data = pkg::ONE;
    step();
    bus.in_valid = 1'b0;
    check("prereset_level", 32'(level), 2);
    rst_n = 1'b0;
    #1;
    check("async_rst_level", 32'(level), 0);
    check("async_rst_valid", 32'(bus.out_valid), 0);
    check("async_rst_data", 32'(bus.out_data), 0);
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
